// File: rtl/fsm_pkg.sv
// Shared types for the escape-sequence detector and the downstream mode FSM:
// one-hot mode state, detector state encoding, escape-sequence character constants.
package fsm_pkg;

    typedef enum logic [3:0] {
        OFF   = 4'b0001,
        PASS  = 4'b0010,
        UPPER = 4'b0100,
        LOWER = 4'b1000
    } state_t;

    typedef enum logic [2:0] {
        DET_IDLE        = 3'd0,
        DET_GOT_ESC     = 3'd1,
        DET_GOT_BRACKET = 3'd2,
        DET_GOT_DIGIT   = 3'd3,
        DET_REPLAY      = 3'd4
    } det_state_t;

    localparam logic [7:0] ESC_CHAR   = 8'h1B;
    localparam logic [7:0] CSI_CHAR   = 8'h5B;
    localparam logic [7:0] TERM_CHAR  = 8'h6D;
    localparam logic [7:0] DIGIT_BASE = 8'h30;

    localparam logic [2:0] BUF_DEPTH  = 3'd4;

    // Mode digits are 0x30..0x33: upper six bits match DIGIT_BASE.
    function automatic logic is_mode_digit(input logic [7:0] c);
        return (c[7:2] == DIGIT_BASE[7:2]);
    endfunction

    function automatic state_t digit_to_state(input logic [1:0] d);
        state_t s;
        case (d)
            2'd0:    s = OFF;
            2'd1:    s = PASS;
            2'd2:    s = UPPER;
            default: s = LOWER;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/esc_replay_buf.sv
// Four-entry in-order character buffer holding a partial escape sequence
// until it is either discarded (sequence completed) or replayed downstream.
module esc_replay_buf
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    input  logic       i_clear,
    output logic [7:0] o_head,
    output logic [2:0] o_count,
    output logic       o_empty
);

    logic [7:0] r_mem [0:3];
    logic [2:0] r_count;

    logic       w_do_pop;
    logic       w_do_push;
    logic [1:0] w_wr_idx;
    logic [7:0] w_next [0:3];

    assign w_do_pop  = i_pop && (r_count != 3'd0);
    assign w_do_push = i_push && ((r_count != BUF_DEPTH) || w_do_pop);
    // Head is always entry 0; a pop shifts everything down, so a same-cycle
    // push lands one slot lower.
    assign w_wr_idx  = w_do_pop ? (r_count[1:0] - 2'd1) : r_count[1:0];

    always_comb begin
        w_next[0] = w_do_pop ? r_mem[1] : r_mem[0];
        w_next[1] = w_do_pop ? r_mem[2] : r_mem[1];
        w_next[2] = w_do_pop ? r_mem[3] : r_mem[2];
        w_next[3] = r_mem[3];
        if (w_do_push) begin
            w_next[w_wr_idx] = i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (i_clear) begin
            r_count <= 3'd0;
        end else begin
            r_count <= r_count + {2'b00, w_do_push} - {2'b00, w_do_pop};
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= w_next[i];
            end
        end
    end

    assign o_head  = r_mem[0];
    assign o_count = r_count;
    assign o_empty = (r_count == 3'd0);

endmodule

// File: rtl/esc_seq_detector.sv
// Scans a character stream for ESC [ d m mode-select sequences, forwarding all
// other characters; `ESC_SEQ_TIMEOUT_EN` adds an idle-timeout abort mid-sequence.
//
// state           | meaning
// DET_IDLE        | pass-through; ESC starts a sequence
// DET_GOT_ESC     | ESC buffered, expecting '['
// DET_GOT_BRACKET | ESC [ buffered, expecting digit 0-3
// DET_GOT_DIGIT   | ESC [ d buffered, expecting 'm'
// DET_REPLAY      | draining the buffer downstream as plain text
module esc_seq_detector
    import fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       mode_changed,
    output logic [3:0] got_esc_sequence
);

    det_state_t r_state;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_mode_changed;
    state_t     r_mode;
    state_t     r_target;

    det_state_t w_state_next;
    logic       w_out_free;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic       w_clear;
    logic       w_load;
    logic [7:0] w_load_data;
    logic       w_seq_done;
    logic       w_timeout_hit;
    logic [7:0] w_buf_head;
    logic [2:0] w_buf_count;
    logic       w_buf_empty;
    logic       w_buf_room;

    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = (r_state != DET_REPLAY) && w_out_free;
    assign w_accept   = in_valid && w_in_ready;
    assign w_buf_room = (w_buf_count != BUF_DEPTH);

`ifdef ESC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_timeout;
    logic            w_in_seq;

    assign w_in_seq      = (r_state == DET_GOT_ESC) || (r_state == DET_GOT_BRACKET) ||
                           (r_state == DET_GOT_DIGIT);
    assign w_timeout_hit = w_in_seq && (r_timeout == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout <= '0;
        end else if (!w_in_seq || w_accept) begin
            r_timeout <= '0;
        end else if (!w_timeout_hit) begin
            r_timeout <= r_timeout + 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_load_data  = in_data;
        w_seq_done   = 1'b0;
        case (r_state)
            DET_IDLE: begin
                if (w_accept) begin
                    if (in_data == ESC_CHAR) begin
                        w_push       = w_buf_room;
                        w_state_next = DET_GOT_ESC;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            DET_GOT_ESC: begin
                if (w_accept) begin
                    w_push       = w_buf_room;
                    w_state_next = (in_data == CSI_CHAR) ? DET_GOT_BRACKET : DET_REPLAY;
                end else if (w_timeout_hit) begin
                    w_state_next = DET_REPLAY;
                end
            end
            DET_GOT_BRACKET: begin
                if (w_accept) begin
                    w_push       = w_buf_room;
                    w_state_next = is_mode_digit(in_data) ? DET_GOT_DIGIT : DET_REPLAY;
                end else if (w_timeout_hit) begin
                    w_state_next = DET_REPLAY;
                end
            end
            DET_GOT_DIGIT: begin
                if (w_accept) begin
                    if (in_data == TERM_CHAR) begin
                        w_clear      = 1'b1;
                        w_seq_done   = 1'b1;
                        w_state_next = DET_IDLE;
                    end else begin
                        w_push       = w_buf_room;
                        w_state_next = DET_REPLAY;
                    end
                end else if (w_timeout_hit) begin
                    w_state_next = DET_REPLAY;
                end
            end
            DET_REPLAY: begin
                // Leave only once the last replayed char is handed off.
                if (w_out_free) begin
                    if (!w_buf_empty) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_load_data = w_buf_head;
                    end else begin
                        w_state_next = DET_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = DET_IDLE;
            end
        endcase
    end

    esc_replay_buf u_replay_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .o_head      (w_buf_head),
        .o_count     (w_buf_count),
        .o_empty     (w_buf_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= DET_IDLE;
            r_out_valid    <= 1'b0;
            r_out_data     <= 8'h00;
            r_mode_changed <= 1'b0;
            r_mode         <= OFF;
            r_target       <= OFF;
        end else begin
            r_state        <= w_state_next;
            r_mode_changed <= w_seq_done;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if ((r_state == DET_GOT_BRACKET) && w_accept && is_mode_digit(in_data)) begin
                r_target <= digit_to_state(in_data[1:0]);
            end
            if (w_seq_done) begin
                r_mode <= r_target;
            end
        end
    end

    assign in_ready         = w_in_ready;
    assign out_data         = r_out_data;
    assign out_valid        = r_out_valid;
    assign mode_changed     = r_mode_changed;
    assign got_esc_sequence = r_mode;

endmodule

// File: tb/tb_esc_seq_detector.sv
// Directed self-checking bench for esc_seq_detector; the timeout scenario
// follows whether ESC_SEQ_TIMEOUT_EN is defined for the build.
module tb_esc_seq_detector;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       mode_changed;
    logic [3:0] got_esc_sequence;

    int         n_cmp;
    int         n_bad;
    int         n_mode;
    logic       tog_en;
    logic [7:0] q_out [$];

    esc_seq_detector #(.TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .mode_changed     (mode_changed),
        .got_esc_sequence (got_esc_sequence)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) q_out.push_back(out_data);
        if (reset && mode_changed === 1'b1) n_mode++;
    end

    always @(posedge clk) begin
        #3;
        if (tog_en) out_ready = ~out_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        q_out.delete();
        n_mode = 0;
    endtask

    // Returns 1 time unit after the edge on which the character was accepted.
    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        in_data = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: char %02h not accepted, in_ready %b, required 1", c, in_ready);
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_q(input int want, input int budget);
        int n;
        n = 0;
        while (q_out.size() < want && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_cmp++;
        if (q_out.size() != want) begin
            n_bad++;
            $display("FAIL out_count: got %0d chars, required %0d", q_out.size(), want);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %02h required 00", out_data); end
        n_cmp++; if (mode_changed !== 1'b0) begin n_bad++; $display("FAIL rst_mode_changed: got %b required 0", mode_changed); end
        n_cmp++; if (got_esc_sequence !== 4'b0001) begin n_bad++; $display("FAIL rst_mode: got %b required 0001", got_esc_sequence); end
    endtask

    task automatic test_pass_through();
        q_out.delete();
        send_char(8'h41);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_bad++; $display("FAIL pass_A: got v=%b d=%02h required v=1 d=41", out_valid, out_data); end
        send_char(8'h42);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h42) begin n_bad++; $display("FAIL pass_B: got v=%b d=%02h required v=1 d=42", out_valid, out_data); end
        @(posedge clk) #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pass_drain: got v=%b required 0", out_valid); end
        n_cmp++; if (q_out.size() != 2) begin n_bad++; $display("FAIL pass_count: got %0d required 2", q_out.size()); end
        n_cmp++; if (n_mode != 0) begin n_bad++; $display("FAIL pass_no_mode: got %0d pulses required 0", n_mode); end
    endtask

    task automatic test_sequence();
        int m0;
        m0 = n_mode;
        q_out.delete();
        send_char(8'h1B); send_char(8'h5B); send_char(8'h32); send_char(8'h6D);
        n_cmp++; if (mode_changed !== 1'b1) begin n_bad++; $display("FAIL seq_pulse: got %b required 1", mode_changed); end
        n_cmp++; if (got_esc_sequence !== 4'b0100) begin n_bad++; $display("FAIL seq_mode: got %b required 0100", got_esc_sequence); end
        @(posedge clk) #1;
        n_cmp++; if (mode_changed !== 1'b0) begin n_bad++; $display("FAIL seq_pulse_end: got %b required 0", mode_changed); end
        n_cmp++; if (got_esc_sequence !== 4'b0100) begin n_bad++; $display("FAIL seq_mode_hold: got %b required 0100", got_esc_sequence); end
        send_char(8'h1B); send_char(8'h5B); send_char(8'h32); send_char(8'h6D);
        @(posedge clk) #1;
        n_cmp++; if (n_mode != m0 + 2) begin n_bad++; $display("FAIL seq_repeat_pulses: got %0d required %0d", n_mode, m0 + 2); end
        n_cmp++; if (q_out.size() != 0) begin n_bad++; $display("FAIL seq_no_output: got %0d chars required 0", q_out.size()); end
    endtask

    task automatic test_abort_replay();
        logic [7:0] exp [3];
        exp = '{8'h1B, 8'h5B, 8'h37};
        apply_reset();
        send_char(8'h1B); send_char(8'h5B); send_char(8'h37);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL replay_in_ready: got %b required 0", in_ready); end
        @(posedge clk) #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h1B) begin n_bad++; $display("FAIL replay_first: got v=%b d=%02h required v=1 d=1b", out_valid, out_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL replay_in_ready2: got %b required 0", in_ready); end
        wait_q(3, 20);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= q_out.size() || q_out[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL replay_char%0d: got %02h required %02h", i, (i < q_out.size()) ? q_out[i] : 8'hxx, exp[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL replay_done: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid); end
        n_cmp++; if (got_esc_sequence !== 4'b0001 || n_mode != 0) begin n_bad++; $display("FAIL replay_mode: got %b/%0d required 0001/0", got_esc_sequence, n_mode); end
    endtask

    task automatic test_stall();
        q_out.delete();
        out_ready = 1'b0;
        send_char(8'h58);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'h58 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got v=%b d=%02h rdy=%b required v=1 d=58 rdy=0", i, out_valid, out_data, in_ready);
            end
            @(posedge clk) #1;
        end
        out_ready = 1'b1;
        @(posedge clk) #1;
        n_cmp++; if (out_valid !== 1'b0 || q_out.size() != 1) begin n_bad++; $display("FAIL stall_release: got v=%b n=%0d required v=0 n=1", out_valid, q_out.size()); end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [7:0] exp [4];
        int m0;
        exp = '{8'h1B, 8'h5B, 8'h31, 8'h41};
        q_out.delete();
        tog_en = 1'b1;
        send_char(8'h1B); send_char(8'h5B); send_char(8'h31); send_char(8'h41);
        wait_q(4, 100);
        tog_en = 1'b0;
        @(posedge clk);
        #4 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (q_out.size() != 4) begin n_bad++; $display("FAIL bp_no_dup: got %0d chars required 4", q_out.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= q_out.size() || q_out[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL bp_char%0d: got %02h required %02h", i, (i < q_out.size()) ? q_out[i] : 8'hxx, exp[i]);
            end
        end
        m0 = n_mode;
        send_char(8'h1B); send_char(8'h5B); send_char(8'h33); send_char(8'h6D);
        n_cmp++; if (got_esc_sequence !== 4'b1000 || mode_changed !== 1'b1) begin n_bad++; $display("FAIL bp_lower: got %b pulse=%b required 1000 pulse=1", got_esc_sequence, mode_changed); end
        @(posedge clk) #1;
        n_cmp++; if (n_mode != m0 + 1) begin n_bad++; $display("FAIL bp_pulse_count: got %0d required %0d", n_mode, m0 + 1); end
    endtask

    task automatic test_reset_mid_seq();
        q_out.delete();
        send_char(8'h1B); send_char(8'h5B);
        reset = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (got_esc_sequence !== 4'b0001) begin n_bad++; $display("FAIL mrst_mode: got %b required 0001", got_esc_sequence); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready: got %b required 1", in_ready); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        send_char(8'h43);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h43) begin n_bad++; $display("FAIL mrst_pass_C: got v=%b d=%02h required v=1 d=43", out_valid, out_data); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (q_out.size() != 1 || q_out[0] !== 8'h43) begin n_bad++; $display("FAIL mrst_only_C: got n=%0d first=%02h required n=1 first=43", q_out.size(), (q_out.size() > 0) ? q_out[0] : 8'hxx); end
    endtask

`ifdef ESC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        send_char(8'h1B);
        repeat (7) @(posedge clk);
        #1;
        n_cmp++; if (q_out.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL to_early: got n=%0d v=%b required n=0 v=0", q_out.size(), out_valid); end
        wait_q(1, 20);
        n_cmp++; if (q_out.size() < 1 || q_out[0] !== 8'h1B) begin n_bad++; $display("FAIL to_replay: got %02h required 1b", (q_out.size() > 0) ? q_out[0] : 8'hxx); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL to_idle: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid); end
    endtask
`else
    task automatic test_timeout();
        apply_reset();
        send_char(8'h1B);
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (q_out.size() != 0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL nto_wait: got n=%0d rdy=%b required n=0 rdy=1", q_out.size(), in_ready); end
        send_char(8'h41);
        wait_q(2, 20);
        n_cmp++;
        if (q_out.size() != 2 || q_out[0] !== 8'h1B || q_out[1] !== 8'h41) begin
            n_bad++;
            $display("FAIL nto_replay: got n=%0d required 1b 41", q_out.size());
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_mode = 0;
        tog_en = 1'b0;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        test_reset();
        test_pass_through();
        test_sequence();
        test_abort_replay();
        test_stall();
        test_back_to_back_backpressure();
        test_reset_mid_seq();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
